mux_rr_str: RTL and testbench
=============================

MUX_RR_STR -- requirements
Module: mux_rr_str

Interface
REQ-001 Parameter WIDTH, default 4: data width per channel in bits, 1 or more.
REQ-002 Parameter CH, default 4: channel count, power of two, 2 or more.
REQ-003 Parameter SELW, default 2: select width, SHALL equal log2(CH).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = explicit select, 1 = round-robin arbitration.
REQ-007 sel  input  SELW  channel index used when mode=0.
REQ-008 in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  CH  per-channel data-valid.
REQ-010 in_ready  output  CH  per-channel accept strobe; combinational.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SELW  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a valid word.
REQ-014 out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-015 Block SHALL contain one output register stage (out_data, out_ch, out_valid) and one round-robin pointer ptr of SELW bits.
REQ-016 Load enable: load = ~out_valid | out_ready.
REQ-017 Mode 0 grant: channel sel, only if in_valid[sel]=1; otherwise no grant.
REQ-018 Mode 1 grant: first channel with in_valid=1 searching ptr, ptr+1, ... circularly modulo CH; no grant if in_valid is all zero.
REQ-019 in_ready[g] SHALL be 1 only for granted channel g and only when load=1; all other bits 0; at most one bit high per cycle.
REQ-020 Transfer: on an edge with load=1 and a grant g, the register SHALL capture out_data=in_data[g], out_ch=g, out_valid=1.
REQ-021 On an edge with load=1 and no grant, out_valid SHALL go 0; out_data/out_ch keep their prior values.
REQ-022 On an edge with load=0 (out_valid=1, out_ready=0), out_data, out_ch and out_valid SHALL hold; in_ready SHALL be all zero.
REQ-023 Latency: input accepted in cycle n appears on out_data in cycle n+1.
REQ-024 Throughput: with out_ready held 1 and a grant every cycle, one word per cycle, no bubbles.
REQ-025 ptr SHALL update to (g+1) mod CH only on a mode-1 transfer; wrap from CH-1 to 0.
REQ-026 ptr SHALL be unchanged in mode 0 and on cycles without transfer.
REQ-027 mode and sel SHALL be sampled each cycle; a change takes effect on that cycle's grant with no flush of the output register.
REQ-028 Upstream data SHALL be consumed only in a cycle where its in_valid and in_ready are both 1.

Reset
REQ-029 While rst=1 at an edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-030 While rst=1, in_ready SHALL be all zero.
REQ-031 rst SHALL take priority over any simultaneous transfer; a word held in the register is discarded.
REQ-032 The first grant after rst deasserts SHALL follow REQ-017/REQ-018 with ptr=0.

Verification
REQ-033 Reset: rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000.
REQ-034 Mode 0 sweep: defaults, out_ready=1; in_data channels {3,2,1,0}={4'hD,4'hC,4'hB,4'hA}; sel stepped 0..3 -> out_data A,B,C,D, one cycle after each sel, out_ch matching.
REQ-035 Mode 0 invalid: sel=2, in_valid=4'b1011 -> in_ready=0000 and out_valid=0 on the next cycle.
REQ-036 Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 (wrap verified).
REQ-037 Round-robin skip: mode=1, ptr=1, in_valid=4'b1001 -> grant 3, then ptr=0 and grant 0.
REQ-038 Backpressure: out_valid=1 with out_data=4'h5, out_ready=0 for 3 cycles -> out_data stays 5, in_ready=0000; out_ready=1 -> next word loads same edge, no bubble.

Source files
------------

// File: rtl/mux_rr_str_if.sv
// mux_rr_str_if: handshake bundle for the mux_rr_str channel selector.
// Signals:
//   mode      - 0 = explicit select, 1 = round-robin arbitration
//   sel       - channel index used in explicit-select mode
//   in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  - per-channel data valid
//   in_ready  - per-channel accept strobe (combinational from the mux)
//   out_data  - registered selected word
//   out_ch    - registered index of the channel that supplied out_data
//   out_valid - out_data/out_ch hold a valid word
//   out_ready - downstream accepts the word
// Modports: master drives the upstream/downstream side, slave is the mux.
interface mux_rr_str_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2
);
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [CH*WIDTH-1:0]   in_data;
  logic [CH-1:0]         in_valid;
  logic [CH-1:0]         in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_str.sv
// mux_rr_str: CH-way channel multiplexer with a single registered output
// stage. Channel choice is either an explicit index (mode=0) or a
// round-robin arbiter starting at pointer ptr (mode=1).
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mux_rr_str_if.slave (mode, sel, in_*, out_*)
// SELW must equal log2(CH); CH must be a power of two.
module mux_rr_str #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_rr_str_if.slave   bus
);

  logic [WIDTH-1:0] w_ch_data [CH];
  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;

  logic             w_load;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_grant_vld;
  logic [SELW-1:0]  w_grant_idx;
  logic [CH-1:0]    w_in_ready;
  logic             w_xfer;

  // Unpack the channel bus into an indexable array
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      w_ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register can take a new word when empty or being drained
  assign w_load = ~r_out_valid | bus.out_ready;

  // Round-robin search: first requester at ptr, ptr+1, ... (SELW-bit add wraps mod CH)
  always_comb begin
    logic [SELW-1:0] v_cand;
    v_cand   = '0;
    w_rr_vld = 1'b0;
    w_rr_idx = r_ptr;
    for (int unsigned k = 0; k < CH; k++) begin
      v_cand = r_ptr + SELW'(k);
      if (!w_rr_vld && bus.in_valid[v_cand]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = v_cand;
      end
    end
  end

  // Grant selection; mode and sel act on the current cycle with no flush
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = bus.sel;
    if (bus.mode) begin
      w_grant_vld = w_rr_vld;
      w_grant_idx = w_rr_idx;
    end else begin
      w_grant_vld = bus.in_valid[bus.sel];
      w_grant_idx = bus.sel;
    end
  end

  // A transfer happens only when out of reset, the register can load and a grant exists
  assign w_xfer = ~rst & w_load & w_grant_vld;

  // One-hot accept strobe towards the granted channel
  always_comb begin
    w_in_ready = '0;
    if (w_xfer) begin
      w_in_ready[w_grant_idx] = 1'b1;
    end
  end

  // Output stage and round-robin pointer; reset wins over any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[w_grant_idx];
        r_out_ch    <= w_grant_idx;
        if (bus.mode) begin
          r_ptr <= w_grant_idx + SELW'(1);
        end
      end else begin
        // Nothing granted: drop valid but keep the stale payload
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_str.sv
// tb_mux_rr_str: scoreboard bench for mux_rr_str. The driver predicts each
// accepted word from a behavioural model and queues it; an independent
// monitor pops and compares whenever the DUT hands a word downstream.
module tb_mux_rr_str;
  localparam int WIDTH = 4;
  localparam int CH    = 4;
  localparam int SELW  = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_str_if #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) bus ();

  mux_rr_str #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    m_ptr  = 0;
  bit    m_ov   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: lowest requester at or above ptr, else lowest overall
  function automatic int rr_pick(input logic [CH-1:0] v, input int p);
    int lowest = -1;
    int above  = -1;
    for (int c = CH - 1; c >= 0; c--) begin
      if (v[c]) begin
        lowest = c;
        if (c >= p) above = c;
      end
    end
    return (above >= 0) ? above : lowest;
  endfunction

  // One clock of stimulus; called just after a rising edge
  task automatic cycle(input bit r, input bit m, input logic [SELW-1:0] s,
                       input logic [CH*WIDTH-1:0] d, input logic [CH-1:0] v,
                       input bit rdy);
    int              g;
    bit              load;
    logic [CH-1:0]   exp_rdy;
    word_t           w;
    rst           = r;
    bus.mode      = m;
    bus.sel       = s;
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    #1;
    load = !m_ov || rdy;
    if (m) g = rr_pick(v, m_ptr);
    else   g = v[s] ? int'(s) : -1;
    exp_rdy = (!r && load && g >= 0) ? CH'(1 << g) : '0;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (r) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      exp_q.delete();
    end else if (load) begin
      if (g >= 0) begin
        w.data = d[g*WIDTH +: WIDTH];
        w.ch   = SELW'(g);
        exp_q.push_back(w);
        m_ov = 1'b1;
        if (m) m_ptr = (g + 1) % CH;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (r) begin
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_ch",   32'(bus.out_ch),   32'h0);
    end
  endtask

  // Monitor: a word leaves the DUT when out_valid and out_ready meet
  always @(negedge clk) begin : mon
    word_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got ch %0d data %0h expected none at %0t",
                 bus.out_ch, bus.out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_ch",   32'(bus.out_ch),   32'(e.ch));
      end
    end
  end

  initial begin
    logic [CH*WIDTH-1:0] dcba;
    dcba = 16'hDCBA;
    rst = 1'b1; bus.mode = 1'b0; bus.sel = '0; bus.in_data = '0;
    bus.in_valid = '0; bus.out_ready = 1'b0;

    // Reset with every channel requesting
    repeat (2) cycle(1, 0, 0, dcba, 4'hF, 1);

    // Explicit select sweep
    for (int s = 0; s < CH; s++) cycle(0, 0, SELW'(s), dcba, 4'hF, 1);

    // Explicit select of an idle channel
    cycle(0, 0, 2, dcba, 4'b1011, 1);
    cycle(0, 0, 2, dcba, 4'b0000, 1);

    // Round-robin fairness and wrap
    repeat (8) cycle(0, 1, 0, dcba, 4'hF, 1);

    // Round-robin skip: set ptr=1, then requesters 0 and 3
    cycle(0, 1, 0, dcba, 4'b0001, 1);
    cycle(0, 1, 0, dcba, 4'b1001, 1);
    cycle(0, 1, 0, dcba, 4'b1001, 1);

    // Backpressure: hold word 5 for three cycles, then stream on
    cycle(0, 0, 1, 16'h0050, 4'hF, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2, 16'h0650, 4'hF, 0);
      chk("hold_data", 32'(bus.out_data), 32'h5);
      chk("hold_ch",   32'(bus.out_ch),   32'h1);
    end
    cycle(0, 0, 2, 16'h0650, 4'hF, 1);
    chk("no_bubble_data", 32'(bus.out_data), 32'h6);
    cycle(0, 0, 0, 16'h0000, 4'h0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), SELW'($urandom),
            (CH*WIDTH)'($urandom), CH'($urandom), ($urandom_range(0, 9) < 7));
    end

    // Drain
    repeat (3) cycle(0, 0, 0, '0, '0, 1);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
